// File: rtl/sys_cmd_ctrl_pkg.sv
// Shared definitions for the UART command sequencer: command opcodes,
// controller state encoding and the fixed RegFile slots for ALU operands.
package sys_ctrl_pkg;

  localparam logic [7:0] CMD_WR      = 8'hAA;
  localparam logic [7:0] CMD_RD      = 8'hBB;
  localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
  localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

  // RegFile locations the ALU reads its operands from
  localparam logic [3:0] ALU_A_ADDR = 4'h0;
  localparam logic [3:0] ALU_B_ADDR = 4'h1;

  typedef enum logic [3:0] {
    IDLE,
    WR_ADDR,
    WR_DATA,
    RD_ADDR,
    RD_WAIT,
    ALU_A,
    ALU_B,
    ALU_FN,
    ALU_GO,
    ALU_WAIT,
    TX_B0,
    TX_B1
  } state_t;

  // States that are waiting for the next byte of a frame from the host
  function automatic logic is_rx_state(input state_t s);
    return (s == WR_ADDR) || (s == WR_DATA) || (s == RD_ADDR) ||
           (s == ALU_A)   || (s == ALU_B)   || (s == ALU_FN);
  endfunction

endpackage

// File: rtl/sys_cmd_ctrl_timer.sv
// Inter-byte frame timer: counts idle cycles while a frame is half received
// and flags expiry when TIMEOUT_CYC-1 cycles have passed without a byte.
module cmd_frame_timer #(
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic clear,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] cnt_reg;

  // Count while a frame is open; any received byte or leaving the frame restarts it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (clear || !run) begin
      cnt_reg <= '0;
    end else if (cnt_reg != LAST) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  // A byte arriving on the expiry cycle still wins over the abort
  assign expired = run && !clear && (cnt_reg == LAST);

endmodule

// File: rtl/sys_cmd_ctrl.sv
// Command sequencer between the UART RX byte stream and the RegFile/ALU.
// Frames: AA addr data (write), BB addr (read), CC A B func (ALU op),
// DD func (ALU op on stored operands). Results go back as TX bytes.
// Optional build macro FRAME_TIMEOUT_EN adds an inter-byte abort timer.
import sys_ctrl_pkg::*;

module sys_cmd_ctrl #(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 4,
  parameter int ALU_W       = 16,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_valid,
  input  logic              rx_err,
  output logic [ADDR_W-1:0] rf_addr,
  output logic              rf_wr_en,
  output logic [DATA_W-1:0] rf_wr_data,
  output logic              rf_rd_en,
  input  logic [DATA_W-1:0] rf_rd_data,
  input  logic              rf_rd_valid,
  output logic              alu_clk_en,
  output logic              alu_en,
  output logic [3:0]        alu_func,
  input  logic [ALU_W-1:0]  alu_out,
  input  logic              alu_out_valid,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy
);

  state_t            state_reg;
  logic [DATA_W-1:0] hi_byte_reg;
  logic              single_reg;
  logic              rx_ok;
  logic              rx_bad;
  logic              timeout_hit;

  assign rx_ok  = rx_valid && !rx_err;
  assign rx_bad = rx_valid && rx_err;

`ifdef FRAME_TIMEOUT_EN
  cmd_frame_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .run     (is_rx_state(state_reg)),
    .clear   (rx_valid),
    .expired (timeout_hit)
  );
`else
  // No timer: a half-received frame waits forever. The parameter is still
  // referenced so both builds share one interface.
  assign timeout_hit = 1'b0 & (TIMEOUT_CYC == 0);
`endif

  assign busy = (state_reg != IDLE);

  // Frame decoder, datapath strobes and TX handshake in one registered FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      rf_addr     <= '0;
      rf_wr_en    <= 1'b0;
      rf_wr_data  <= '0;
      rf_rd_en    <= 1'b0;
      alu_clk_en  <= 1'b0;
      alu_en      <= 1'b0;
      alu_func    <= '0;
      tx_data     <= '0;
      tx_valid    <= 1'b0;
      hi_byte_reg <= '0;
      single_reg  <= 1'b0;
    end else begin
      rf_wr_en <= 1'b0;
      rf_rd_en <= 1'b0;
      alu_en   <= 1'b0;
      if (timeout_hit) begin
        state_reg <= IDLE;
      end else begin
        unique case (state_reg)
          IDLE: begin
            if (rx_ok) begin
              if (rx_data[7:0] == CMD_WR)           state_reg <= WR_ADDR;
              else if (rx_data[7:0] == CMD_RD)      state_reg <= RD_ADDR;
              else if (rx_data[7:0] == CMD_ALU_OP)  state_reg <= ALU_A;
              else if (rx_data[7:0] == CMD_ALU_NOP) state_reg <= ALU_FN;
            end
          end
          WR_ADDR: begin
            if (rx_bad) begin
              state_reg <= IDLE;
            end else if (rx_ok) begin
              rf_addr   <= rx_data[ADDR_W-1:0];
              state_reg <= WR_DATA;
            end
          end
          WR_DATA: begin
            if (rx_bad) begin
              state_reg <= IDLE;
            end else if (rx_ok) begin
              rf_wr_data <= rx_data;
              rf_wr_en   <= 1'b1;
              state_reg  <= IDLE;
            end
          end
          RD_ADDR: begin
            if (rx_bad) begin
              state_reg <= IDLE;
            end else if (rx_ok) begin
              rf_addr   <= rx_data[ADDR_W-1:0];
              rf_rd_en  <= 1'b1;
              state_reg <= RD_WAIT;
            end
          end
          RD_WAIT: begin
            if (rf_rd_valid) begin
              tx_data    <= rf_rd_data;
              tx_valid   <= 1'b1;
              single_reg <= 1'b1;
              state_reg  <= TX_B0;
            end
          end
          ALU_A: begin
            if (rx_bad) begin
              state_reg <= IDLE;
            end else if (rx_ok) begin
              rf_addr    <= ADDR_W'(ALU_A_ADDR);
              rf_wr_data <= rx_data;
              rf_wr_en   <= 1'b1;
              state_reg  <= ALU_B;
            end
          end
          ALU_B: begin
            if (rx_bad) begin
              state_reg <= IDLE;
            end else if (rx_ok) begin
              rf_addr    <= ADDR_W'(ALU_B_ADDR);
              rf_wr_data <= rx_data;
              rf_wr_en   <= 1'b1;
              state_reg  <= ALU_FN;
            end
          end
          ALU_FN: begin
            if (rx_bad) begin
              state_reg <= IDLE;
            end else if (rx_ok) begin
              alu_func   <= rx_data[3:0];
              alu_clk_en <= 1'b1;
              state_reg  <= ALU_GO;
            end
          end
          ALU_GO: begin
            // The gated ALU clock has had one cycle to settle; start it now
            alu_en    <= 1'b1;
            state_reg <= ALU_WAIT;
          end
          ALU_WAIT: begin
            if (alu_out_valid) begin
              tx_data     <= alu_out[DATA_W-1:0];
              hi_byte_reg <= alu_out[DATA_W +: DATA_W];
              single_reg  <= 1'b0;
              tx_valid    <= 1'b1;
              alu_clk_en  <= 1'b0;
              state_reg   <= TX_B0;
            end
          end
          TX_B0: begin
            if (tx_ready) begin
              if (single_reg) begin
                tx_valid  <= 1'b0;
                state_reg <= IDLE;
              end else begin
                tx_data   <= hi_byte_reg;
                state_reg <= TX_B1;
              end
            end
          end
          TX_B1: begin
            if (tx_ready) begin
              tx_valid  <= 1'b0;
              state_reg <= IDLE;
            end
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sys_cmd_ctrl.sv
// Self-checking bench for sys_cmd_ctrl: a frame-level model predicts RF
// writes/reads, ALU starts and TX bytes; a per-cycle monitor checks the DUT.
`timescale 1ns/1ps
module tb_sys_cmd_ctrl;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;
  localparam int ALU_W  = 16;
  localparam int TO_CYC = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_err;
  logic [ADDR_W-1:0] rf_addr;
  logic              rf_wr_en;
  logic [DATA_W-1:0] rf_wr_data;
  logic              rf_rd_en;
  logic [DATA_W-1:0] rf_rd_data;
  logic              rf_rd_valid;
  logic              alu_clk_en;
  logic              alu_en;
  logic [3:0]        alu_func;
  logic [ALU_W-1:0]  alu_out;
  logic              alu_out_valid;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              busy;

  sys_cmd_ctrl #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ALU_W(ALU_W), .TIMEOUT_CYC(TO_CYC)
  ) dut (
    .clk(clk), .rst(rst),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_err(rx_err),
    .rf_addr(rf_addr), .rf_wr_en(rf_wr_en), .rf_wr_data(rf_wr_data),
    .rf_rd_en(rf_rd_en), .rf_rd_data(rf_rd_data), .rf_rd_valid(rf_rd_valid),
    .alu_clk_en(alu_clk_en), .alu_en(alu_en), .alu_func(alu_func),
    .alu_out(alu_out), .alu_out_valid(alu_out_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- environment: RegFile and ALU the DUT talks to ----------
  logic [7:0] dev_rf [16];
  int         alu_delay = 5;

  function automatic logic [15:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                          input logic [3:0] fn);
    case (fn)
      4'd0:    return {8'h00, a} + {8'h00, b};
      4'd1:    return {8'h00, a} - {8'h00, b};
      4'd2:    return {8'h00, a} * {8'h00, b};
      default: return {a ^ b, a & b};
    endcase
  endfunction

  initial begin
    int rd_cnt;
    int alu_cnt;
    logic [3:0]  rd_a;
    logic [15:0] alu_res;
    rd_cnt = 0; alu_cnt = 0; rd_a = '0; alu_res = '0;
    rf_rd_valid = 1'b0; rf_rd_data = '0; alu_out_valid = 1'b0; alu_out = '0;
    forever begin
      @(negedge clk);
      rf_rd_valid   = 1'b0;
      alu_out_valid = 1'b0;
      if (!rst && rf_wr_en) dev_rf[rf_addr] = rf_wr_data;
      if (rd_cnt > 0) begin
        rd_cnt--;
        if (rd_cnt == 0) begin rf_rd_valid = 1'b1; rf_rd_data = dev_rf[rd_a]; end
      end
      if (!rst && rf_rd_en) begin rd_cnt = 2; rd_a = rf_addr; end
      if (alu_cnt > 0) begin
        alu_cnt--;
        if (alu_cnt == 0) begin alu_out_valid = 1'b1; alu_out = alu_res; end
      end
      if (!rst && alu_en) begin
        alu_cnt = alu_delay;
        alu_res = alu_ref(dev_rf[0], dev_rf[1], alu_func);
      end
    end
  end

  // ---------------- frame-level model ---------------------------------------
  logic [7:0]  model_rf [16];
  logic [11:0] exp_wr[$];
  logic [3:0]  exp_rd[$];
  logic [3:0]  exp_alu[$];
  logic [7:0]  exp_tx[$];

  task automatic model_alu(input logic [3:0] fn, input bit lost);
    logic [15:0] r;
    exp_alu.push_back(fn);
    if (!lost) begin
      r = alu_ref(model_rf[0], model_rf[1], fn);
      exp_tx.push_back(r[7:0]);
      exp_tx.push_back(r[15:8]);
    end
  endtask

  task automatic model_write(input logic [3:0] a, input logic [7:0] d);
    exp_wr.push_back({a, d});
    model_rf[a] = d;
  endtask

  // n_ok: how many leading bytes arrive clean (-1: all); lost: result never sent
  task automatic model_expect(input logic [7:0] fr[$], input int n_ok, input bit lost);
    int n;
    logic [7:0] b1, b2, b3;
    n  = (n_ok < 0) ? fr.size() : n_ok;
    b1 = (fr.size() > 1) ? fr[1] : 8'h00;
    b2 = (fr.size() > 2) ? fr[2] : 8'h00;
    b3 = (fr.size() > 3) ? fr[3] : 8'h00;
    if (n < 1) return;
    case (fr[0])
      8'hAA: if (n >= 3) model_write(b1[3:0], b2);
      8'hBB: if (n >= 2) begin
        exp_rd.push_back(b1[3:0]);
        if (!lost) exp_tx.push_back(model_rf[b1[3:0]]);
      end
      8'hCC: begin
        if (n >= 2) model_write(4'h0, b1);
        if (n >= 3) model_write(4'h1, b2);
        if (n >= 4) model_alu(b3[3:0], lost);
      end
      8'hDD: if (n >= 2) model_alu(b1[3:0], lost);
      default: ;
    endcase
  endtask

  // ---------------- per-cycle monitor ---------------------------------------
  initial begin
    logic        hold;
    logic [7:0]  held;
    logic [11:0] w;
    hold = 1'b0; held = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        hold = 1'b0;
      end else begin
        if (rf_wr_en) begin
          check("rf_wr_expected", exp_wr.size() > 0, 1);
          if (exp_wr.size() > 0) begin
            w = exp_wr.pop_front();
            check("rf_wr_addr", rf_addr, w[11:8]);
            check("rf_wr_data", rf_wr_data, w[7:0]);
          end
        end
        if (rf_rd_en) begin
          check("rf_rd_expected", exp_rd.size() > 0, 1);
          if (exp_rd.size() > 0) check("rf_rd_addr", rf_addr, exp_rd.pop_front());
        end
        if (alu_en) begin
          check("alu_en_expected", exp_alu.size() > 0, 1);
          check("alu_clk_en_at_start", alu_clk_en, 1);
          if (exp_alu.size() > 0) check("alu_func", alu_func, exp_alu.pop_front());
        end
        if (tx_valid && hold) check("tx_data_stable", tx_data, held);
        if (tx_valid && tx_ready) begin
          check("tx_expected", exp_tx.size() > 0, 1);
          if (exp_tx.size() > 0) check("tx_data", tx_data, exp_tx.pop_front());
        end
        hold = tx_valid && !tx_ready;
        held = tx_data;
        if (!busy) begin
          check("idle_tx_valid", tx_valid, 0);
          check("idle_alu_clk_en", alu_clk_en, 0);
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------------------------------
  task automatic send_frame(input logic [7:0] fr[$], input int err_idx);
    for (int i = 0; i < fr.size(); i++) begin
      @(posedge clk); #1;
      rx_data  = fr[i];
      rx_err   = (i == err_idx);
      rx_valid = 1'b1;
      if (i == err_idx) break;
    end
    @(posedge clk); #1;
    rx_valid = 1'b0;
    rx_err   = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    bit done;
    done = 1'b0;
    for (int c = 0; c < 500 && !done; c++) begin
      @(negedge clk);
      if (!busy && !tx_valid) done = 1'b1;
    end
    check({name, "_reached_idle"}, done, 1);
    repeat (4) @(negedge clk);
    check({name, "_wr_left"},  exp_wr.size(),  0);
    check({name, "_rd_left"},  exp_rd.size(),  0);
    check({name, "_alu_left"}, exp_alu.size(), 0);
    check({name, "_tx_left"},  exp_tx.size(),  0);
    $display("[%0t] frame %s complete", $time, name);
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_busy"},       busy, 0);
    check({name, "_tx_valid"},   tx_valid, 0);
    check({name, "_tx_data"},    tx_data, 0);
    check({name, "_rf_wr_en"},   rf_wr_en, 0);
    check({name, "_rf_rd_en"},   rf_rd_en, 0);
    check({name, "_rf_addr"},    rf_addr, 0);
    check({name, "_rf_wr_data"}, rf_wr_data, 0);
    check({name, "_alu_en"},     alu_en, 0);
    check({name, "_alu_clk_en"}, alu_clk_en, 0);
    check({name, "_alu_func"},   alu_func, 0);
  endtask

  // ---------------- directed sequence ---------------------------------------
  logic [7:0] f[$];

  initial begin
    rx_data = '0; rx_valid = 1'b0; rx_err = 1'b0; tx_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin dev_rf[i] = 8'h00; model_rf[i] = 8'h00; end
    repeat (3) @(posedge clk); #1;
    check_all_zero("reset");
    rst = 1'b0;

    // write 0xAB to address 5
    f = '{8'hAA, 8'h05, 8'hAB};
    model_expect(f, -1, 1'b0);
    send_frame(f, -1);
    wait_idle("wr_05");
    check("rf5_contents", dev_rf[5], 8'hAB);

    // read it back
    f = '{8'hBB, 8'h05};
    model_expect(f, -1, 1'b0);
    check("model_rd05_byte", exp_tx[0], 8'hAB);
    send_frame(f, -1);
    wait_idle("rd_05");

    // address byte truncated to its low nibble
    f = '{8'hAA, 8'hF3, 8'h5A};
    model_expect(f, -1, 1'b0);
    send_frame(f, -1);
    wait_idle("wr_f3");
    f = '{8'hBB, 8'h13};
    model_expect(f, -1, 1'b0);
    check("model_rd13_byte", exp_tx[0], 8'h5A);
    send_frame(f, -1);
    wait_idle("rd_13");

    // ALU op 8 + 4
    f = '{8'hCC, 8'h08, 8'h04, 8'h00};
    model_expect(f, -1, 1'b0);
    check("model_add_lo", exp_tx[0], 8'h0C);
    check("model_add_hi", exp_tx[1], 8'h00);
    send_frame(f, -1);
    wait_idle("alu_add");
    check("alu_clk_en_after_add", alu_clk_en, 0);

    // ALU_NOP subtract with TX stalled; trailing byte lands in ALU_GO and is dropped
    tx_ready = 1'b0;
    f = '{8'hDD, 8'h01, 8'hAA};
    model_expect(f, -1, 1'b0);
    check("model_sub_lo", exp_tx[0], 8'h04);
    check("model_sub_hi", exp_tx[1], 8'h00);
    send_frame(f, -1);
    begin
      bit seen;
      seen = 1'b0;
      for (int c = 0; c < 50 && !seen; c++) begin
        @(negedge clk);
        if (tx_valid) seen = 1'b1;
      end
      check("nop_tx_valid_seen", seen, 1);
    end
    repeat (100) @(negedge clk);
    check("nop_tx_held_byte", tx_data, 8'h04);
    check("nop_busy_while_held", busy, 1);
    @(posedge clk); #1;
    tx_ready = 1'b1;
    wait_idle("alu_nop_stall");

    // error byte aborts a write frame
    f = '{8'hAA, 8'h05, 8'h77};
    model_expect(f, 2, 1'b0);
    send_frame(f, 2);
    check("err_abort_busy", busy, 0);
    wait_idle("wr_err");
    check("rf5_unchanged", dev_rf[5], 8'hAB);

    // unknown command byte
    f = '{8'h55};
    model_expect(f, -1, 1'b0);
    send_frame(f, -1);
    check("unknown_cmd_busy", busy, 0);
    wait_idle("unknown_55");

    // reset in ALU_WAIT; the late alu_out_valid must be ignored in IDLE
    alu_delay = 20;
    f = '{8'hDD, 8'h00};
    model_expect(f, -1, 1'b1);
    send_frame(f, -1);
    repeat (6) @(posedge clk);
    #1;
    check("pre_reset_busy", busy, 1);
    rst = 1'b1;
    #1;
    check_all_zero("mid_reset");
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (30) @(negedge clk);
    check("post_reset_busy", busy, 0);
    wait_idle("reset_alu_wait");
    alu_delay = 5;

`ifdef FRAME_TIMEOUT_EN
    // frame timer aborts an unfinished ALU_OP frame
    f = '{8'hCC, 8'h08};
    model_expect(f, -1, 1'b0);
    send_frame(f, -1);
    repeat (TO_CYC - 1) @(posedge clk);
    #1;
    check("timeout_still_busy", busy, 1);
    @(posedge clk); #1;
    check("timeout_aborted", busy, 0);
    repeat (8) @(posedge clk);
    f = '{8'h04};
    model_expect(f, -1, 1'b0);
    send_frame(f, -1);
    check("late_byte_ignored", busy, 0);
    wait_idle("timeout");
`endif

    // controller still healthy afterwards
    f = '{8'hBB, 8'h05};
    model_expect(f, -1, 1'b0);
    check("model_final_rd_byte", exp_tx[0], 8'hAB);
    send_frame(f, -1);
    wait_idle("rd_final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
